// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: result inputs, register file write ports and status of the writeback queue
interface regfile_wb_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          v0, v1, v2;
  logic [5:0]    wa0, wa1, wa2;
  logic [31:0]   wd0, wd1, wd2;
  logic          in_ready;
  logic          we_a, we_b;
  logic [5:0]    addr_a, addr_b;
  logic [31:0]   data_a, data_b;
  logic [CW-1:0] count;
  logic          empty;
  modport master (
    output v0, v1, v2, wa0, wa1, wa2, wd0, wd1, wd2,
    input  in_ready, we_a, we_b, addr_a, addr_b, data_a, data_b, count, empty
  );
  modport slave (
    input  v0, v1, v2, wa0, wa1, wa2, wd0, wd1, wd2,
    output in_ready, we_a, we_b, addr_a, addr_b, data_a, data_b, count, empty
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order 3-in/2-out writeback buffer feeding a 2-write-port register file
module regfile_wb_queue #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [5:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] head, tail, head1, p1, p2;
  logic [CW-1:0] count;
  logic          rdy, acc0, acc1, acc2, we_a, we_b;
  logic [1:0]    pushes, pops;
  // Accept decode, compacted write slots and issue selection; outputs depend on registers and rst_n only
  always_comb begin
    rdy = rst_n & (count <= CW'(DEPTH - 3));
    acc0 = bus.v0 & rdy & (bus.wa0 != 6'd0);
    acc1 = bus.v1 & rdy & (bus.wa1 != 6'd0);
    acc2 = bus.v2 & rdy & (bus.wa2 != 6'd0);
    p1 = tail + PW'(acc0);
    p2 = p1 + PW'(acc1);
    pushes = 2'(acc0) + 2'(acc1) + 2'(acc2);
    head1 = head + PW'(1);
    we_a = rst_n & (count != '0);
    we_b = rst_n & (count >= CW'(2)) & (mem_addr[head1] != mem_addr[head]);
    pops = 2'(we_a) + 2'(we_b);
    bus.in_ready = rdy;
    bus.we_a = we_a;
    bus.we_b = we_b;
    bus.addr_a = we_a ? mem_addr[head] : 6'd0;
    bus.data_a = we_a ? mem_data[head] : 32'd0;
    bus.addr_b = we_b ? mem_addr[head1] : 6'd0;
    bus.data_b = we_b ? mem_data[head1] : 32'd0;
    bus.count = count;
    bus.empty = count == '0;
  end
  // Pointer and occupancy update; reset discards everything pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PW'(pops);
      tail <= p2 + PW'(acc2);
      count <= count + CW'(pushes) - CW'(pops);
    end
  end
  // Storage writes; the in_ready margin guarantees these slots never hold live entries
  always_ff @(posedge clk) begin
    if (acc0) begin
      mem_addr[tail] <= bus.wa0;
      mem_data[tail] <= bus.wd0;
    end
    if (acc1) begin
      mem_addr[p1] <= bus.wa1;
      mem_data[p1] <= bus.wd1;
    end
    if (acc2) begin
      mem_addr[p2] <= bus.wa2;
      mem_data[p2] <= bus.wd2;
    end
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed and randomized checks of the writeback queue against a queue-based model
module tb_regfile_wb_queue;
  localparam int DEPTH = 8;
  typedef struct packed {logic [5:0] a; logic [31:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();
  regfile_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  ent_t q[$];
  logic [31:0] exp_rf [64] = '{default: 32'd0};
  logic [31:0] obs_rf [64] = '{default: 32'd0};
  int n_checks = 0;
  int n_fail = 0;
  int zero_hits = 0;
  int dup_hits = 0;
  logic e_ready, e_we_a, e_we_b;
  logic [5:0] e_addr_a, e_addr_b;
  logic [31:0] e_data_a, e_data_b;
  // Register file as seen through the DUT's write ports, sampled mid-cycle
  always @(negedge clk) begin
    if ((bus.we_a && bus.addr_a == 6'd0) || (bus.we_b && bus.addr_b == 6'd0)) zero_hits++;
    if (bus.we_a && bus.we_b && bus.addr_a == bus.addr_b) dup_hits++;
    if (bus.we_a) obs_rf[bus.addr_a] = bus.data_a;
    if (bus.we_b) obs_rf[bus.addr_b] = bus.data_b;
  end
  function automatic void model_exp();
    e_ready = rst_n && q.size() <= DEPTH - 3;
    e_we_a = rst_n && q.size() >= 1;
    e_we_b = 1'b0;
    if (rst_n && q.size() >= 2) e_we_b = q[1].a != q[0].a;
    e_addr_a = e_we_a ? q[0].a : 6'd0;
    e_data_a = e_we_a ? q[0].d : 32'd0;
    e_addr_b = e_we_b ? q[1].a : 6'd0;
    e_data_b = e_we_b ? q[1].d : 32'd0;
  endfunction
  task automatic step(input logic rn, input logic [2:0] v, input logic [5:0] a0, a1, a2,
                      input logic [31:0] d0, d1, d2);
    logic [5:0] aa [3];
    logic [31:0] dd [3];
    ent_t e;
    int n;
    aa = '{a0, a1, a2};
    dd = '{d0, d1, d2};
    rst_n = rn;
    {bus.v2, bus.v1, bus.v0} = v;
    {bus.wa0, bus.wa1, bus.wa2} = {a0, a1, a2};
    {bus.wd0, bus.wd1, bus.wd2} = {d0, d1, d2};
    model_exp();
    if (!rn) q.delete();
    else begin
      n = int'(e_we_a) + int'(e_we_b);
      repeat (n) begin
        exp_rf[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (e_ready)
        for (int i = 0; i < 3; i++)
          if (v[i] && aa[i] != 6'd0) begin
            e.a = aa[i];
            e.d = dd[i];
            q.push_back(e);
          end
    end
    @(posedge clk);
    #1;
    {bus.v0, bus.v1, bus.v2} = 3'b000;
  endtask
  task automatic idle();
    step(1'b1, 3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 3'b111, 6'd1, 6'd2, 6'd3, 32'h1, 32'h2, 32'h3);
      n_checks++;
      if ({bus.in_ready, bus.we_a, bus.we_b} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold: in_ready/we_a/we_b=%b expected 000", {bus.in_ready, bus.we_a, bus.we_b});
      end
      n_checks++;
      if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_count: count=%0d empty=%b expected 0/1", bus.count, bus.empty);
      end
    end
    step(1'b1, 3'b001, 6'd5, 6'd0, 6'd0, 32'hAAAA, 32'd0, 32'd0);
    n_checks++;
    if ({bus.we_a, bus.addr_a, bus.data_a, bus.we_b} !== {1'b1, 6'd5, 32'hAAAA, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_push: we_a=%b addr_a=%0d data_a=%h we_b=%b expected 1/5/0000aaaa/0",
               bus.we_a, bus.addr_a, bus.data_a, bus.we_b);
    end
    idle();
    n_checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_drained: count=%0d empty=%b expected 0/1", bus.count, bus.empty);
    end
  endtask
  task automatic test_triple();
    step(1'b1, 3'b111, 6'd1, 6'd2, 6'd3, 32'h11, 32'h22, 32'h33);
    n_checks++;
    if ({bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.addr_b, bus.data_b, bus.count} !==
        {1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 4'd3}) begin
      n_fail++;
      $display("FAIL triple_c1: A=%b/%0d/%h B=%b/%0d/%h count=%0d expected A=1/1/11 B=1/2/22 count=3",
               bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.addr_b, bus.data_b, bus.count);
    end
    idle();
    n_checks++;
    if ({bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.count} !== {1'b1, 6'd3, 32'h33, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL triple_c2: A=%b/%0d/%h we_b=%b count=%0d expected A=1/3/33 we_b=0 count=1",
               bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.count);
    end
    idle();
    n_checks++;
    if (bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL triple_empty: empty=%b expected 1", bus.empty);
    end
  endtask
  task automatic test_zero_drop();
    step(1'b1, 3'b111, 6'd0, 6'd4, 6'd0, 32'hFF, 32'h44, 32'hEE);
    n_checks++;
    if ({bus.count, bus.we_a, bus.addr_a, bus.data_a, bus.we_b} !== {4'd1, 1'b1, 6'd4, 32'h44, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_drop: count=%0d A=%b/%0d/%h we_b=%b expected count=1 A=1/4/44 we_b=0",
               bus.count, bus.we_a, bus.addr_a, bus.data_a, bus.we_b);
    end
    idle();
    n_checks++;
    if (bus.empty !== 1'b1 || zero_hits !== 0) begin
      n_fail++;
      $display("FAIL zero_drop_drain: empty=%b zero_writes=%0d expected 1/0", bus.empty, zero_hits);
    end
  endtask
  task automatic test_conflict();
    step(1'b1, 3'b011, 6'd7, 6'd7, 6'd0, 32'h1, 32'h2, 32'h0);
    n_checks++;
    if ({bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.count} !== {1'b1, 6'd7, 32'h1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL conflict_c1: A=%b/%0d/%h we_b=%b count=%0d expected A=1/7/1 we_b=0 count=2",
               bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.count);
    end
    idle();
    n_checks++;
    if ({bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.count} !== {1'b1, 6'd7, 32'h2, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL conflict_c2: A=%b/%0d/%h we_b=%b count=%0d expected A=1/7/2 we_b=0 count=1",
               bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.count);
    end
    idle();
    n_checks++;
    if (obs_rf[7] !== 32'h2) begin
      n_fail++;
      $display("FAIL conflict_rf: reg7=%h expected 00000002", obs_rf[7]);
    end
  endtask
  task automatic test_full_wrap();
    logic saw_block;
    int diffs;
    saw_block = 1'b0;
    for (int c = 0; c < 24; c++) begin
      model_exp();
      n_checks++;
      if ({bus.in_ready, bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.addr_b, bus.data_b, bus.count} !==
          {e_ready, e_we_a, e_addr_a, e_data_a, e_we_b, e_addr_b, e_data_b, 4'(q.size())}) begin
        n_fail++;
        $display("FAIL wrap_cycle%0d: rdy=%b A=%b/%0d/%h B=%b/%0d/%h count=%0d expected rdy=%b A=%b/%0d/%h B=%b/%0d/%h count=%0d",
                 c, bus.in_ready, bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.addr_b, bus.data_b, bus.count,
                 e_ready, e_we_a, e_addr_a, e_data_a, e_we_b, e_addr_b, e_data_b, q.size());
      end
      if (!bus.in_ready) saw_block = 1'b1;
      if (c < 4) step(1'b1, 3'b111, 6'(20 + 3 * c), 6'(21 + 3 * c), 6'(22 + 3 * c), $urandom, $urandom, $urandom);
      else idle();
    end
    diffs = 0;
    for (int r = 0; r < 64; r++) if (obs_rf[r] !== exp_rf[r]) diffs++;
    n_checks++;
    if (!saw_block || diffs != 0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_final: saw_backpressure=%b rf_diffs=%0d empty=%b expected 1/0/1", saw_block, diffs, bus.empty);
    end
  endtask
  task automatic test_random();
    logic [2:0] v;
    logic [5:0] a [3];
    for (int c = 0; c < 120; c++) begin
      model_exp();
      n_checks++;
      if ({bus.in_ready, bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.addr_b, bus.data_b, bus.count, bus.empty} !==
          {e_ready, e_we_a, e_addr_a, e_data_a, e_we_b, e_addr_b, e_data_b, 4'(q.size()), q.size() == 0}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: rdy=%b A=%b/%0d/%h B=%b/%0d/%h count=%0d expected rdy=%b A=%b/%0d/%h B=%b/%0d/%h count=%0d",
                 c, bus.in_ready, bus.we_a, bus.addr_a, bus.data_a, bus.we_b, bus.addr_b, bus.data_b, bus.count,
                 e_ready, e_we_a, e_addr_a, e_data_a, e_we_b, e_addr_b, e_data_b, q.size());
      end
      v = (c < 100) ? 3'($urandom) : 3'b000;
      for (int i = 0; i < 3; i++) a[i] = 6'($urandom_range(0, 7));
      step(1'b1, v, a[0], a[1], a[2], $urandom, $urandom, $urandom);
    end
  endtask
  task automatic test_reset_mid();
    int k;
    int diffs;
    for (int n = 0; n < 5 && q.size() < 6; n++) begin
      k = (q.size() == 0) ? 3 : ((7 - q.size()) < 3 ? 7 - q.size() : 3);
      step(1'b1, 3'((1 << k) - 1), 6'd10, 6'd10, 6'd10, 32'h100 + n, 32'h200 + n, 32'h300 + n);
    end
    n_checks++;
    if (bus.count !== 4'd6) begin
      n_fail++;
      $display("FAIL midrst_fill: count=%0d expected 6", bus.count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.we_a, bus.we_b, bus.in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_no_write: we_a/we_b/in_ready=%b expected 000", {bus.we_a, bus.we_b, bus.in_ready});
    end
    step(1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_cleared: count=%0d empty=%b expected 0/1", bus.count, bus.empty);
    end
    repeat (4) idle();
    diffs = 0;
    for (int r = 0; r < 64; r++) if (obs_rf[r] !== exp_rf[r]) diffs++;
    n_checks++;
    if (diffs != 0 || bus.we_a !== 1'b0 || zero_hits != 0 || dup_hits != 0) begin
      n_fail++;
      $display("FAIL midrst_final: rf_diffs=%0d we_a=%b zero_writes=%0d dup_writes=%0d expected 0/0/0/0",
               diffs, bus.we_a, zero_hits, dup_hits);
    end
  endtask
  initial begin
    {bus.v0, bus.v1, bus.v2} = 3'b000;
    {bus.wa0, bus.wa1, bus.wa2} = '0;
    {bus.wd0, bus.wd1, bus.wd2} = '0;
    #1;
    test_reset();
    test_triple();
    test_zero_drop();
    test_conflict();
    test_full_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue sitting directly upstream of the 2-write/4-read register file. Collects up to three results per cycle from the execution units (ALU0, ALU1, MEM) into a shared in-order circular buffer. Drains up to two entries per cycle onto the register file's two write ports (A, B). Guarantees the register file never sees two same-address writes in one cycle, and that program order (last writer wins) is preserved.

## Interface
- `DEPTH`, default 8: buffer entries; power of two, ≥4.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `v0`, `v1`, `v2` in 1 each: result valid, sources 0/1/2; source 0 oldest within a cycle.
- `wa0`, `wa1`, `wa2` in 6 each: destination register address.
- `wd0`, `wd1`, `wd2` in 32 each: result data.
- `in_ready` out 1: shared accept signal for all three sources.
- `we_a` out 1, `addr_a` out 6, `data_a` out 32: register file port A write.
- `we_b` out 1, `addr_b` out 6, `data_b` out 32: register file port B write.
- `count` out log2(DEPTH)+1: current occupancy.
- `empty` out 1: `count == 0`.

## Operation
- **Storage:** circular buffer of {addr[5:0], data[31:0]}, with `head`/`tail` pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a `count` register.
- **Accept:** `in_ready = (count <= DEPTH-3)`, taken from the registered count only; same-cycle pops are not credited. A source is accepted when `vX & in_ready`.
- **Push:**
  - Accepted entries with a nonzero address are written at `tail`, `tail+1`, … in source order 0, 1, 2, compacted with no holes.
  - Accepted entries with address 0 are consumed and discarded: never stored, never counted. Register 0 is hardwired zero.
- **Issue:** port A always takes the entry at `head`; port B takes the entry at `head+1`.
  - `we_a = (count ≥ 1)`.
  - `we_b = (count ≥ 2) & (addr[head+1] != addr[head])`.
  - On an address conflict only A issues. The newer entry moves to `head` and issues next cycle, so the newer value lands last.
- **Pop count** is `we_a + we_b`; pops happen in the same cycle as issue (the register file always accepts).
- **Counter update:** `count_next = count + pushes_nonzero − pops`. Maximum +3/−2; overflow is impossible given the `in_ready` rule.
- **Idle outputs:** when `we_a=0`, `addr_a` and `data_a` are 0; likewise for port B.
- **Reset** (`rst_n=0` at a rising edge):
  - `head`, `tail` and `count` are cleared to 0, so `empty=1`.
  - `we_a`, `we_b`, `addr_*` and `data_*` are 0.
  - `in_ready` is 0 while `rst_n` is low.
  - Reset mid-drain discards all pending entries; no write is issued in the reset cycle.

## Timing
- Outputs depend only on registers; there is no combinational path from `vX`/`waX`/`wdX` to any output.
- **Latency:** an entry pushed at edge k is presented on port A/B in the cycle after edge k. The register file commits it at edge k+1.
- **Minimum drain:** an entry reaches the head only after all older entries have issued. Throughput is at most 2 writes/cycle.
- **Simultaneous push and pop** in the same cycle are legal. A pop never exposes an entry pushed in that same cycle until the next edge.
- `in_ready` falls the cycle after `count` exceeds DEPTH−3. It rises the cycle after `count` drops to DEPTH−3 or below.
- **Wrap:** pointers roll from DEPTH−1 to 0. The `head+1` read wraps identically.

## Test plan
- **Reset:** hold `rst_n=0` with `v0..v2=1` → `in_ready=0`, `we_a=we_b=0`, `count=0`. Release; push {5,0xAAAA} → next cycle `we_a=1`, `addr_a=5`, `data_a=0xAAAA`, `we_b=0`; then `count=0`.
- **Triple push:** one cycle with {1,0x11}, {2,0x22}, {3,0x33} → cycle 1: A=1/0x11, B=2/0x22; cycle 2: A=3/0x33, `we_b=0`; then `empty=1`.
- **Zero drop:** push {0,0xFF}, {4,0x44}, {0,0xEE} → `count=1`; only A=4/0x44 issues; no write to address 0 is ever seen.
- **Conflict:** push {7,0x1}, {7,0x2} → cycle 1: A=7/0x1, `we_b=0`; cycle 2: A=7/0x2. Register 7 reads 0x2 afterwards.
- **Full/backpressure and wrap** (DEPTH=8): push 3 per cycle for 4 cycles, all nonzero and distinct addresses → `in_ready` deasserts once `count>5`, and no accepted entry is lost. Continue for 20 cycles: all entries drain in push order across pointer wrap, with `count` matching the scoreboard every cycle.
- **Reset mid-drain:** with `count=6`, assert `rst_n=0` for one edge → no writes that cycle; `count=0`, `empty=1`. Earlier-pending entries never appear afterwards.
